// File: rtl/mult_div_if.sv
// Operand/result bundle between the register-file read ports and the
// iterative multiply/divide unit.
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO pair.
// Shift-add multiply and restoring divide on unsigned magnitudes, sign fixed in a final cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  mult_div_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_r;
  logic [CW-1:0]      count_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   opnd_r;
  logic               is_div_r;
  logic               neg_res_r;
  logic               neg_rem_r;
  logic               busy_r;
  logic               done_r;
  logic               div_zero_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               signed_op_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic               b_zero_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_trial_s;
  logic [2*WIDTH-1:0] acc_step_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Operand magnitudes and signs for the request currently on the bus
  always_comb begin
    signed_op_s = ~bus.op[0];
    a_neg_s     = signed_op_s & bus.a[WIDTH-1];
    b_neg_s     = signed_op_s & bus.b[WIDTH-1];
    b_zero_s    = (bus.b == {WIDTH{1'b0}});
    if (a_neg_s) begin
      a_mag_s = neg_w(bus.a);
    end else begin
      a_mag_s = bus.a;
    end
    if (b_neg_s) begin
      b_mag_s = neg_w(bus.b);
    end else begin
      b_mag_s = bus.b;
    end
  end

  // One iteration: acc upper half is partial product / remainder, lower half
  // is the multiplier being consumed / the dividend shifting into the quotient
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                  (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_trial_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]} - {1'b0, opnd_r};
    if (is_div_r) begin
      if (!div_trial_s[WIDTH]) begin
        acc_step_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_step_s = {acc_r[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end
  end

  // Final sign correction applied in FIX
  always_comb begin
    if (neg_res_r) begin
      prod_fix_s = neg_2w(acc_r);
      quo_fix_s  = neg_w(acc_r[WIDTH-1:0]);
    end else begin
      prod_fix_s = acc_r;
      quo_fix_s  = acc_r[WIDTH-1:0];
    end
    if (neg_rem_r) begin
      rem_fix_s = neg_w(acc_r[2*WIDTH-1:WIDTH]);
    end else begin
      rem_fix_s = acc_r[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      count_r    <= {CW{1'b0}};
      acc_r      <= {(2*WIDTH){1'b0}};
      opnd_r     <= {WIDTH{1'b0}};
      is_div_r   <= 1'b0;
      neg_res_r  <= 1'b0;
      neg_rem_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
              3'b000, 3'b001: begin
                acc_r      <= {{WIDTH{1'b0}}, b_mag_s};
                opnd_r     <= a_mag_s;
                is_div_r   <= 1'b0;
                neg_res_r  <= a_neg_s ^ b_neg_s;
                neg_rem_r  <= 1'b0;
                count_r    <= {CW{1'b0}};
                busy_r     <= 1'b1;
                div_zero_r <= 1'b0;
                state_r    <= CALC;
              end
              3'b010, 3'b011: begin
                if (b_zero_s) begin
                  lo_r       <= {WIDTH{1'b1}};
                  hi_r       <= bus.a;
                  div_zero_r <= 1'b1;
                  done_r     <= 1'b1;
                end else begin
                  acc_r      <= {{WIDTH{1'b0}}, a_mag_s};
                  opnd_r     <= b_mag_s;
                  is_div_r   <= 1'b1;
                  neg_res_r  <= a_neg_s ^ b_neg_s;
                  neg_rem_r  <= a_neg_s;
                  count_r    <= {CW{1'b0}};
                  busy_r     <= 1'b1;
                  div_zero_r <= 1'b0;
                  state_r    <= CALC;
                end
              end
              3'b100: begin
                hi_r       <= bus.a;
                div_zero_r <= 1'b0;
              end
              3'b101: begin
                lo_r       <= bus.a;
                div_zero_r <= 1'b0;
              end
              default: begin
                state_r <= IDLE;
              end
            endcase
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          acc_r   <= acc_step_s;
          count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
          if (count_r == LAST_COUNT) begin
            state_r <= FIX;
          end else begin
            state_r <= CALC;
          end
        end
        FIX: begin
          if (is_div_r) begin
            hi_r <= rem_fix_s;
            lo_r <= quo_fix_s;
          end else begin
            hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
            lo_r <= prod_fix_s[WIDTH-1:0];
          end
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized bench for mult_div_unit against an arithmetic reference model
// (64-bit products, language division/remainder).
module tb_mult_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_div_if #(.WIDTH(W)) bus ();
  mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;
  logic        exp_dz = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: architectural result of one accepted op
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'b000: begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; exp_dz = 1'b0; end
      3'b001: begin p = {32'd0, a} * {32'd0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; exp_dz = 1'b0; end
      3'b010, 3'b011: begin
        if (b == 32'd0) begin
          exp_lo = 32'hFFFF_FFFF; exp_hi = a; exp_dz = 1'b1;
        end else if (op == 3'b010) begin
          q = sa / sb; r = sa % sb;
          exp_lo = q[31:0]; exp_hi = r[31:0]; exp_dz = 1'b0;
        end else begin
          exp_lo = a / b; exp_hi = a % b; exp_dz = 1'b0;
        end
      end
      3'b100: begin exp_hi = a; exp_dz = 1'b0; end
      3'b101: begin exp_lo = a; exp_dz = 1'b0; end
      default: begin end
    endcase
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit stray);
    int n;
    bit busy_drop;
    logic [31:0] old_hi, old_lo;
    old_hi = exp_hi;
    old_lo = exp_lo;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    model(op, a, b);
    if (op[2] == 1'b0 && !(op[1] && b == 32'd0)) begin
      check_val("busy_t0", {63'd0, bus.busy}, 64'd1);
      n = 0;
      busy_drop = 1'b0;
      while (bus.done !== 1'b1 && n < 40) begin
        if (stray) begin
          bus.start = 1'($urandom_range(0, 1));
          bus.op = 3'($urandom);
        end
        @(posedge clk); #1;
        n++;
        if (bus.done !== 1'b1 && bus.busy !== 1'b1) busy_drop = 1'b1;
        if (n == 16) check_val("hold_hilo", {bus.hi, bus.lo}, {old_hi, old_lo});
      end
      bus.start = 1'b0;
      check_val("latency", 64'(n), 64'd33);
      check_val("busy_steady", {63'd0, busy_drop}, 64'd0);
      check_val("busy_done", {63'd0, bus.busy}, 64'd0);
    end else if (op[2] == 1'b0) begin
      check_val("dz_done", {63'd0, bus.done}, 64'd1);
      check_val("dz_busy", {63'd0, bus.busy}, 64'd0);
    end else begin
      check_val("mt_done", {62'd0, bus.done, bus.busy}, 64'd0);
    end
    check_val("hi", {32'd0, bus.hi}, {32'd0, exp_hi});
    check_val("lo", {32'd0, bus.lo}, {32'd0, exp_lo});
    check_val("div_zero", {63'd0, bus.div_zero}, {63'd0, exp_dz});
  endtask

  initial begin
    int dones;
    logic [2:0] rop;
    logic [31:0] ra, rb;
    bus.start = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_state", {59'd0, bus.busy, bus.done, bus.div_zero, 2'd0}, 64'd0);
    check_val("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'b000, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(posedge clk); #1;
    check_val("done_pulse", {63'd0, bus.done}, 64'd0);
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'b011, 32'd7, 32'd2, 1'b0);
    run_op(3'b011, 32'd1234, 32'd0, 1'b0);
    run_op(3'b100, 32'hDEAD_BEEF, 32'd0, 1'b0);
    run_op(3'b001, 32'd5, 32'd6, 1'b1);
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b101, 32'h1357_9BDF, 32'd0, 1'b0);
    run_op(3'b110, 32'h1111_1111, 32'd3, 1'b0);
    run_op(3'b010, 32'd100, 32'd0, 1'b0);
    run_op(3'b111, 32'h2222_2222, 32'd0, 1'b0);

    // Reset in the middle of a divide abandons it
    bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'hFFFF_FF9C; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_val("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
    check_val("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
    rst_n = 1'b1;
    exp_hi = 32'd0; exp_lo = 32'd0; exp_dz = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    check_val("rst_no_done", 64'(dones), 64'd0);

    for (int i = 0; i < 80; i++) begin
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
